hit_detector: RTL and testbench

- Upstream stage of the score counter. Turns raw, bouncy player buttons into clean press events and judges each press against the currently visible mole.
- Emits a single-cycle `hit` (drives the score counter's `hit`) and a single-cycle `miss`.
- Guarantees at most one `hit` per mole appearance.
- Sits between the button pins / mole spawner and the score counter.

---
 rtl/hit_detector_pkg.sv | 17 +
 rtl/hit_detector_if.sv | 31 +++
 rtl/hit_detector_button_debounce.sv | 58 +++++
 rtl/hit_detector.sv | 73 +++++++
 tb/tb_hit_detector.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hit_detector_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | whack_pkg : shared sizing for the mole game input path               |
// | Rev 1.0   : initial release                                          |
// +----------------------------------------------------------------------+
package whack_pkg;

  localparam int N_MOLES_DEF         = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 50000;
  localparam int DEBOUNCE_CYCLES_SIM = 4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hit_detector_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hit_detector_if : buttons / mole spawner in, clean levels and pulses |
// | Rev 1.0         : initial release                                    |
// +----------------------------------------------------------------------+
interface hit_detector_if
  import whack_pkg::*;
#(
  parameter int N_MOLES = N_MOLES_DEF,
  parameter int IDX_W   = idx_width(N_MOLES)
);
  logic [N_MOLES-1:0] btn;
  logic               enable;
  logic               mole_valid;
  logic [IDX_W-1:0]   mole_idx;
  logic               mole_new;
  logic [N_MOLES-1:0] btn_clean;
  logic               hit;
  logic               miss;

  modport master (
    output btn, enable, mole_valid, mole_idx, mole_new,
    input  btn_clean, hit, miss
  );

  modport slave (
    input  btn, enable, mole_valid, mole_idx, mole_new,
    output btn_clean, hit, miss
  );
endinterface
`default_nettype wire

// File: rtl/hit_detector_button_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | button_debounce : 2-flop sync, stability counter, press-edge pulse   |
// | Rev 1.0         : initial release                                    |
// +----------------------------------------------------------------------+
module button_debounce
  import whack_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic clean_o,
  output logic press_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             clean_q, clean_d;
  logic             clean_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronized level disagrees with clean,
  // and is cleared on acceptance, so it never reaches a wrap.
  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    if (s2_q != clean_q) begin
      if (cnt_q == CNT_LAST) begin
        clean_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      cnt_q        <= '0;
      clean_q      <= 1'b0;
      clean_prev_q <= 1'b0;
    end else begin
      s1_q         <= btn_i;
      s2_q         <= s1_q;
      cnt_q        <= cnt_d;
      clean_q      <= clean_d;
      clean_prev_q <= clean_q;
    end
  end

  assign clean_o = clean_q;
  assign press_o = clean_q & ~clean_prev_q;
endmodule
`default_nettype wire

// File: rtl/hit_detector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hit_detector : debounced presses judged against the visible mole     |
// | Rev 1.0      : initial release                                       |
// +----------------------------------------------------------------------+
module hit_detector
  import whack_pkg::*;
#(
  parameter int N_MOLES         = N_MOLES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int IDX_W           = idx_width(N_MOLES)
) (
  input  logic           clk,
  input  logic           reset,
  hit_detector_if.slave  bus
);
  logic [N_MOLES-1:0] press;
  logic [N_MOLES-1:0] clean;
  logic               sel_press;
  logic               armed_q, armed_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;

  generate
    for (genvar i = 0; i < N_MOLES; i++) begin : g_btn
      button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (bus.btn[i]),
        .clean_o (clean[i]),
        .press_o (press[i])
      );
    end
  endgenerate

  always_comb begin
    // An out-of-range index matches no button, so any press becomes a miss.
    sel_press = 1'b0;
    for (int i = 0; i < N_MOLES; i++) begin
      if (int'(bus.mole_idx) == i) sel_press = press[i];
    end

    hit_d   = 1'b0;
    miss_d  = 1'b0;
    armed_d = armed_q;
    if (bus.enable && bus.mole_valid && !bus.mole_new && (|press)) begin
      if (sel_press && armed_q) hit_d  = 1'b1;
      else                      miss_d = 1'b1;
    end

    if (bus.mole_new)                                    armed_d = 1'b1;
    else if (hit_d || !bus.mole_valid || !bus.enable)    armed_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      armed_q <= 1'b0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      armed_q <= armed_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign bus.btn_clean = clean;
  assign bus.hit       = hit_q;
  assign bus.miss      = miss_q;
endmodule
`default_nettype wire

// File: tb/tb_hit_detector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hit_detector : scoreboard bench for hit_detector (DC=4, 4 moles)  |
// | Rev 1.0         : initial release                                    |
// +----------------------------------------------------------------------+
module tb_hit_detector;
  import whack_pkg::*;

  localparam int NM = 4;
  localparam int DC = DEBOUNCE_CYCLES_SIM;
  localparam int IW = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hit_detector_if #(.N_MOLES(NM), .IDX_W(IW)) bus ();

  hit_detector #(
    .N_MOLES         (NM),
    .DEBOUNCE_CYCLES (DC),
    .IDX_W           (IW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic          rst_n;
    logic          en;
    logic          valid;
    logic [IW-1:0] idx;
    logic          mnew;
    logic [NM-1:0] btn;
  } stim_t;

  typedef struct packed {
    logic          hit;
    logic          miss;
    logic [NM-1:0] clean;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_hits   = 0;

  always @(negedge clk) if (bus.hit === 1'b1) n_hits++;

  function automatic stim_t mk(logic rst_n, logic en, logic valid, logic [IW-1:0] idx,
                               logic mnew, logic [NM-1:0] btn);
    stim_t s;
    s.rst_n = rst_n; s.en = en; s.valid = valid; s.idx = idx; s.mnew = mnew; s.btn = btn;
    return s;
  endfunction

  function automatic exp_t mkx(logic hit, logic miss, logic [NM-1:0] clean);
    exp_t e;
    e.hit = hit; e.miss = miss; e.clean = clean;
    return e;
  endfunction

  // Button first sampled at edge s, released (sampled low) at edge e.
  function automatic logic lvl(int k, int s, int e);
    return (k >= s + DC + 1) && (k < e + DC + 1);
  endfunction

  function automatic logic pulse(int k, int s);
    return k == s + DC + 2;
  endfunction

  function automatic logic on(int k, int s, int e);
    return (k >= s) && (k < e);
  endfunction

  task automatic drive(input stim_t s);
    reset          = s.rst_n;
    bus.enable     = s.en;
    bus.mole_valid = s.valid;
    bus.mole_idx   = s.idx;
    bus.mole_new   = s.mnew;
    bus.btn        = s.btn;
  endtask

  task automatic test_reset();
    drive(mk(1'b0, 1'b1, 1'b0, '0, 1'b0, '0));
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.hit, bus.miss, bus.btn_clean} !== '0)
      $display("FAIL reset: hit=%b miss=%b btn_clean=%b, expected all 0", bus.hit, bus.miss, bus.btn_clean);
    else n_pass++;
  endtask

  task automatic test_clean_press();
    exp_t e;
    for (int k = 0; k < 21; k++) begin
      stim_q.push_back(mk(1'b1, 1'b1, 1'b1, 3'd2, k == 0, {1'b0, on(k, 1, 13), 2'b00}));
      exp_q.push_back(mkx(pulse(k, 1), 1'b0, {1'b0, lvl(k, 1, 13), 2'b00}));
    end
    for (int k = 0; stim_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_checks++;
      if ({bus.hit, bus.miss, bus.btn_clean} !== {e.hit, e.miss, e.clean})
        $display("FAIL clean_press k=%0d: hit=%b miss=%b btn_clean=%b, expected hit=%b miss=%b btn_clean=%b",
                 k, bus.hit, bus.miss, bus.btn_clean, e.hit, e.miss, e.clean);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    exp_t e;
    logic b;
    for (int k = 0; k < 31; k++) begin
      b = on(k, 1, 3) | on(k, 5, 7) | on(k, 9, 21);
      stim_q.push_back(mk(1'b1, 1'b1, 1'b1, 3'd1, k == 0, {2'b00, b, 1'b0}));
      exp_q.push_back(mkx(pulse(k, 9), 1'b0, {2'b00, lvl(k, 9, 21), 1'b0}));
    end
    for (int k = 0; stim_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_checks++;
      if ({bus.hit, bus.miss, bus.btn_clean} !== {e.hit, e.miss, e.clean})
        $display("FAIL bounce k=%0d: hit=%b miss=%b btn_clean=%b, expected hit=%b miss=%b btn_clean=%b",
                 k, bus.hit, bus.miss, bus.btn_clean, e.hit, e.miss, e.clean);
      else n_pass++;
    end
  endtask

  task automatic test_repeat_wrong();
    exp_t e;
    int   hits0;
    logic b0, b3;
    hits0 = n_hits;
    for (int k = 0; k < 61; k++) begin
      b0 = on(k, 1, 11) | on(k, 21, 31);
      b3 = on(k, 41, 51);
      stim_q.push_back(mk(1'b1, 1'b1, 1'b1, 3'd0, k == 0, {b3, 2'b00, b0}));
      exp_q.push_back(mkx(pulse(k, 1), pulse(k, 21) | pulse(k, 41),
                          {lvl(k, 41, 51), 2'b00, lvl(k, 1, 11) | lvl(k, 21, 31)}));
    end
    for (int k = 0; stim_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_checks++;
      if ({bus.hit, bus.miss, bus.btn_clean} !== {e.hit, e.miss, e.clean})
        $display("FAIL repeat_wrong k=%0d: hit=%b miss=%b btn_clean=%b, expected hit=%b miss=%b btn_clean=%b",
                 k, bus.hit, bus.miss, bus.btn_clean, e.hit, e.miss, e.clean);
      else n_pass++;
    end
    n_checks++;
    if (n_hits - hits0 !== 1)
      $display("FAIL repeat_score: hits counted=%0d, expected 1", n_hits - hits0);
    else n_pass++;
  endtask

  task automatic test_priority_gating();
    exp_t e;
    logic p;
    // Two buttons together on an armed mole, then the same with enable low.
    for (int k = 0; k < 42; k++) begin
      p = on(k, 1, 11) | on(k, 22, 32);
      stim_q.push_back(mk(1'b1, k < 21, 1'b1, 3'd1, k == 0 || k == 21, {2'b00, p, p}));
      exp_q.push_back(mkx(pulse(k, 1), 1'b0,
                          {2'b00, {2{lvl(k, 1, 11) | lvl(k, 22, 32)}}}));
    end
    // A press whose judgement edge coincides with mole_new, then a normal press.
    for (int k = 0; k < 40; k++) begin
      p = on(k, 1, 11) | on(k, 21, 31);
      stim_q.push_back(mk(1'b1, 1'b1, 1'b1, 3'd1, k == 1 + DC + 2, {2'b00, p, 1'b0}));
      exp_q.push_back(mkx(pulse(k, 21), 1'b0, {2'b00, lvl(k, 1, 11) | lvl(k, 21, 31), 1'b0}));
    end
    for (int k = 0; stim_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_checks++;
      if ({bus.hit, bus.miss, bus.btn_clean} !== {e.hit, e.miss, e.clean})
        $display("FAIL priority_gating k=%0d: hit=%b miss=%b btn_clean=%b, expected hit=%b miss=%b btn_clean=%b",
                 k, bus.hit, bus.miss, bus.btn_clean, e.hit, e.miss, e.clean);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_debounce();
    exp_t e;
    // btn3 first sampled at edge 1; counter is at 2 before edge 5, where reset hits.
    for (int k = 0; k < 30; k++) begin
      stim_q.push_back(mk(k != 5, 1'b1, k != 0, 3'd0, 1'b0, {on(k, 1, 20), 3'b000}));
      exp_q.push_back(mkx(1'b0, k == 12, {(k >= 11) && (k < 20 + DC + 1), 3'b000}));
    end
    for (int k = 0; stim_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_checks++;
      if ({bus.hit, bus.miss, bus.btn_clean} !== {e.hit, e.miss, e.clean})
        $display("FAIL reset_mid_debounce k=%0d: hit=%b miss=%b btn_clean=%b, expected hit=%b miss=%b btn_clean=%b",
                 k, bus.hit, bus.miss, bus.btn_clean, e.hit, e.miss, e.clean);
      else n_pass++;
    end
  endtask

  task automatic test_out_of_range();
    exp_t e;
    for (int k = 0; k < 21; k++) begin
      stim_q.push_back(mk(1'b1, 1'b1, 1'b1, 3'd5, k == 0, {1'b0, on(k, 1, 11), 2'b00}));
      exp_q.push_back(mkx(1'b0, pulse(k, 1), {1'b0, lvl(k, 1, 11), 2'b00}));
    end
    for (int k = 0; stim_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_checks++;
      if ({bus.hit, bus.miss, bus.btn_clean} !== {e.hit, e.miss, e.clean})
        $display("FAIL out_of_range k=%0d: hit=%b miss=%b btn_clean=%b, expected hit=%b miss=%b btn_clean=%b",
                 k, bus.hit, bus.miss, bus.btn_clean, e.hit, e.miss, e.clean);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat_wrong();
    test_priority_gating();
    test_reset_mid_debounce();
    test_out_of_range();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
